alu_sekuencer: RTL and testbench
================================

# alu_sekuencer

- Multi-cycle control FSM for the CPU16 ALU result path.
- Accepts one operation per Start pulse and decodes the 4-bit opcode into the 5-bit select code of the 6:1 result mux, the subtract and shift controls, and the register-file write strobe.
- Shift operations take one cycle per bit position.
- Sits between the instruction decoder and the ALU/register-file write port.

## Interface
- ALU_SEK_W, default 16: datapath width; bounds the shift amount and sizes the optional operation counter.
- Clock  in  1  single clock; all state changes on the rising edge.
- Reset  in  1  synchronous, active-high; forces IDLE and all outputs to 0.
- Start  in  1  request a new operation; sampled only in IDLE.
- Opcode  in  4  operation code; captured on the accepting edge.
- Shamt  in  4  shift amount, 0..15; captured with Opcode.
- S  out  5  result-mux select; registered.
- Binvert  out  1  inverts the adder B operand (SUB, SLT).
- ShiftDir  out  1  0 = left, 1 = right.
- ShiftEn  out  1  one-bit shift strobe to the shifter register.
- WriteEn  out  1  register-file write strobe, one cycle.
- Done  out  1  one-cycle completion pulse.
- Busy  out  1  high in every state except IDLE.
- Err  out  1  one-cycle pulse with Done for an illegal opcode.

## Operation
- States and transitions:
  - IDLE: leave on Start; capture Opcode and Shamt.
  - DECODE: always exactly one cycle.
  - EXEC: one cycle for non-shift ops; Shamt cycles for shifts.
  - WRITE: one cycle, then back to IDLE.
- Opcode to S mapping (mux source in brackets):
  - 0 AND: S=2 (hyrja0).
  - 1 OR: S=1 (hyrja1).
  - 2 ADD: S=4 (hyrja2).
  - 3 SUB: S=4 (hyrja2), Binvert=1.
  - 4 SLT: S=3 (hyrja4), Binvert=1.
  - 5 SLL: S=5 (hyrja5), ShiftDir=0.
  - 6 SRL: S=5 (hyrja5), ShiftDir=1.
  - 7 PASS: S=0 (hyrja3).
- S, Binvert and ShiftDir are registered in DECODE and held through WRITE; all three are 0 in IDLE.
- Shift ops:
  - A down-counter is loaded with Shamt in DECODE.
  - ShiftEn is high for each EXEC cycle; the counter decrements each cycle; EXEC exits when the counter reaches 1.
  - Shamt=0: DECODE goes directly to WRITE, ShiftEn is never asserted, WriteEn is still asserted.
- Illegal opcodes 8..15:
  - S=0 and Binvert=0 throughout.
  - Sequence is DECODE then WRITE, skipping EXEC.
  - In WRITE, WriteEn=0, Done=1, Err=1.
- Start in any state other than IDLE is ignored, not queued.
- Start held continuously: a new operation is accepted on the first IDLE cycle after WRITE.
- Reset mid-operation aborts immediately: no Done, no WriteEn, no further ShiftEn; next cycle is IDLE.

## Timing
- Start sampled high at edge 0 → DECODE in cycle 1.
- Non-shift ops: EXEC in cycle 2, WRITE in cycle 3 (Done, WriteEn), IDLE in cycle 4. Latency is 3 cycles; throughput is one op per 4 cycles.
- Shift with Shamt=N≥1: EXEC in cycles 2..N+1, WRITE in cycle N+2.
- Shamt=0 and illegal opcodes: WRITE in cycle 2.
- All outputs are registered; no combinational path from any input to any output.
- Reset value of every output is 0.

## Configuration
- ALU_SEK_PERF_EN defined:
  - Adds output OpCount, ALU_SEK_W bits.
  - Increments on every cycle with WriteEn=1 and wraps from all-ones to 0.
  - Cleared by Reset.
  - Illegal ops are not counted.
- ALU_SEK_PERF_EN undefined: OpCount port and counter are absent; behaviour is otherwise identical.

## Structure
- Shared package alu_pkg holds:
  - opcode localparams OP_AND..OP_PASS;
  - mux-select constants SEL_AND=2, SEL_OR=1, SEL_ADD=4, SEL_SLT=3, SEL_SHF=5, SEL_PASS=0;
  - the state enumeration.
- One sub-module, alu_dekoder: a combinational opcode → {S, Binvert, ShiftDir, is_shift, illegal} decoder, instantiated by the FSM and registered in DECODE.

## Test plan
- After Reset, Start=1 with Opcode=2 → S=4 in cycles 1..3, Binvert=0, WriteEn=Done=1 in cycle 3 only, Busy low in cycle 4.
- Opcode=3 → S=4, Binvert=1; Opcode=4 → S=3, Binvert=1; Opcode=7 → S=0; each Done in cycle 3.
- Opcode=6 with Shamt=5 → ShiftDir=1, ShiftEn high in cycles 2..6 (exactly 5 pulses), Done in cycle 7. Opcode=5 with Shamt=0 → no ShiftEn, Done in cycle 2.
- Opcode=9 → S=0, Done=Err=1 and WriteEn=0 in cycle 2; with ALU_SEK_PERF_EN, OpCount is unchanged.
- Start asserted while Busy, and Start held high across WRITE → no extra acceptance; the second op begins DECODE exactly one cycle after its predecessor returns to IDLE.
- Reset asserted in cycle 4 of a Shamt=10 shift → cycle 5 is IDLE, all outputs 0, no Done; OpCount=0 with ALU_SEK_PERF_EN.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcodes, result-mux select codes and FSM state codes for the CPU16 ALU sequencer.
// Latency: n/a (constants only). Backpressure: n/a.
package alu_pkg;

    localparam logic [3:0] OP_AND  = 4'd0;
    localparam logic [3:0] OP_OR   = 4'd1;
    localparam logic [3:0] OP_ADD  = 4'd2;
    localparam logic [3:0] OP_SUB  = 4'd3;
    localparam logic [3:0] OP_SLT  = 4'd4;
    localparam logic [3:0] OP_SLL  = 4'd5;
    localparam logic [3:0] OP_SRL  = 4'd6;
    localparam logic [3:0] OP_PASS = 4'd7;

    localparam logic [4:0] SEL_AND  = 5'd2;
    localparam logic [4:0] SEL_OR   = 5'd1;
    localparam logic [4:0] SEL_ADD  = 5'd4;
    localparam logic [4:0] SEL_SLT  = 5'd3;
    localparam logic [4:0] SEL_SHF  = 5'd5;
    localparam logic [4:0] SEL_PASS = 5'd0;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_DECODE = 2'd1;
    localparam state_t ST_EXEC   = 2'd2;
    localparam state_t ST_WRITE  = 2'd3;

endpackage

// File: rtl/alu_dekoder.sv
// Combinational opcode decoder: mux select, subtract/shift controls, shift and illegal flags.
// Latency: 0 cycles. Backpressure: none.
module alu_dekoder
    import alu_pkg::*;
(
    input  logic [3:0] opcode,
    output logic [4:0] sel,
    output logic       binvert,
    output logic       shift_dir,
    output logic       is_shift,
    output logic       illegal
);

    always_comb begin
        sel       = SEL_PASS;
        binvert   = 1'b0;
        shift_dir = 1'b0;
        is_shift  = 1'b0;
        illegal   = 1'b0;
        case (opcode)
            OP_AND:  sel = SEL_AND;
            OP_OR:   sel = SEL_OR;
            OP_ADD:  sel = SEL_ADD;
            OP_SUB:  begin sel = SEL_ADD; binvert = 1'b1; end
            OP_SLT:  begin sel = SEL_SLT; binvert = 1'b1; end
            OP_SLL:  begin sel = SEL_SHF; is_shift = 1'b1; end
            OP_SRL:  begin sel = SEL_SHF; is_shift = 1'b1; shift_dir = 1'b1; end
            OP_PASS: sel = SEL_PASS;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_sekuencer.sv
// ALU result-path sequencer (IDLE/DECODE/EXEC/WRITE); optional OpCount under ALU_SEK_PERF_EN.
// Latency: Done 3 cycles after accept (shift N>=1: N+2, Shamt=0/illegal: 2). Backpressure: Start ignored while Busy.
module alu_sekuencer
    import alu_pkg::*;
#(
    parameter int ALU_SEK_W = 16
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 Start,
    input  logic [3:0]           Opcode,
    input  logic [3:0]           Shamt,
    output logic [4:0]           S,
    output logic                 Binvert,
    output logic                 ShiftDir,
    output logic                 ShiftEn,
    output logic                 WriteEn,
    output logic                 Done,
    output logic                 Busy,
`ifdef ALU_SEK_PERF_EN
    output logic [ALU_SEK_W-1:0] OpCount,
`endif
    output logic                 Err
);

    localparam int         SHAMT_LIM = (ALU_SEK_W > 16) ? 15 : ALU_SEK_W - 1;
    localparam logic [3:0] SHAMT_MAX = SHAMT_LIM[3:0];

    state_t     state, nxt;
    logic [3:0] cnt;
    logic       shift_q, illegal_q;
    logic [4:0] dec_sel;
    logic       dec_binv, dec_dir, dec_shift, dec_ill;
    logic [3:0] shamt_eff;
    logic       accept;

    alu_dekoder u_dek (
        .opcode    (Opcode),
        .sel       (dec_sel),
        .binvert   (dec_binv),
        .shift_dir (dec_dir),
        .is_shift  (dec_shift),
        .illegal   (dec_ill)
    );

    assign accept    = (state == ST_IDLE) && Start;
    assign shamt_eff = (Shamt > SHAMT_MAX) ? SHAMT_MAX : Shamt;

    always_comb begin
        nxt = state;
        case (state)
            ST_IDLE:   if (Start) nxt = ST_DECODE;
            ST_DECODE: nxt = (illegal_q || (shift_q && cnt == 4'd0)) ? ST_WRITE : ST_EXEC;
            ST_EXEC:   if (!shift_q || cnt == 4'd1) nxt = ST_WRITE;
            default:   nxt = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so each one is valid in the state it belongs to.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state     <= ST_IDLE;
            cnt       <= 4'd0;
            shift_q   <= 1'b0;
            illegal_q <= 1'b0;
            S         <= 5'd0;
            Binvert   <= 1'b0;
            ShiftDir  <= 1'b0;
            ShiftEn   <= 1'b0;
            WriteEn   <= 1'b0;
            Done      <= 1'b0;
            Busy      <= 1'b0;
            Err       <= 1'b0;
        end else begin
            state   <= nxt;
            Busy    <= (nxt != ST_IDLE);
            Done    <= (nxt == ST_WRITE);
            WriteEn <= (nxt == ST_WRITE) && !illegal_q;
            Err     <= (nxt == ST_WRITE) && illegal_q;
            ShiftEn <= (nxt == ST_EXEC) && shift_q;
            if (accept) begin
                S         <= dec_sel;
                Binvert   <= dec_binv;
                ShiftDir  <= dec_dir;
                shift_q   <= dec_shift;
                illegal_q <= dec_ill;
                cnt       <= shamt_eff;
            end else if (nxt == ST_IDLE) begin
                S        <= 5'd0;
                Binvert  <= 1'b0;
                ShiftDir <= 1'b0;
            end
            if (state == ST_EXEC && shift_q && cnt != 4'd1)
                cnt <= cnt - 4'd1;
        end
    end

`ifdef ALU_SEK_PERF_EN
    always_ff @(posedge Clock) begin
        if (Reset)
            OpCount <= '0;
        else if (WriteEn)
            OpCount <= OpCount + 1'b1;
    end
`endif

endmodule

// File: tb/tb_alu_sekuencer.sv
// Scoreboard bench for alu_sekuencer: driver pushes expected op timelines, monitor checks every cycle.
module tb_alu_sekuencer;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic        Start = 1'b0;
    logic [3:0]  Opcode = 4'd0;
    logic [3:0]  Shamt = 4'd0;
    logic [4:0]  S;
    logic        Binvert, ShiftDir, ShiftEn, WriteEn, Done, Busy, Err;
`ifdef ALU_SEK_PERF_EN
    logic [15:0] OpCount;
`endif

    alu_sekuencer #(.ALU_SEK_W(16)) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .Start    (Start),
        .Opcode   (Opcode),
        .Shamt    (Shamt),
        .S        (S),
        .Binvert  (Binvert),
        .ShiftDir (ShiftDir),
        .ShiftEn  (ShiftEn),
        .WriteEn  (WriteEn),
        .Done     (Done),
        .Busy     (Busy),
`ifdef ALU_SEK_PERF_EN
        .OpCount  (OpCount),
`endif
        .Err      (Err)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        int         acc;   // edge number that accepted the op
        int         w;     // cycle index of WRITE relative to the accept edge
        int         sh;
        logic [4:0] s;
        logic       binv;
        logic       sdir;
        logic       shift;
        logic       ill;
    } op_t;

    op_t         q[$];
    int          ecount = 0;
    int          next_free = 0;
    int          n_checks = 0;
    int          n_errors = 0;
    bit          started = 1'b0;
    logic [15:0] opcnt = 16'd0;

    always @(posedge Clock) ecount <= ecount + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", nm, act, exp, ecount);
        end
    endtask

    // Reference: the operation table written out directly from the opcode list.
    function automatic op_t model(input int op, input int sh, input int acc);
        op_t m;
        m.acc = acc; m.sh = sh; m.s = 5'd0; m.binv = 0; m.sdir = 0; m.shift = 0; m.ill = 0;
        case (op)
            0: m.s = 5'd2;
            1: m.s = 5'd1;
            2: m.s = 5'd4;
            3: begin m.s = 5'd4; m.binv = 1; end
            4: begin m.s = 5'd3; m.binv = 1; end
            5: begin m.s = 5'd5; m.shift = 1; end
            6: begin m.s = 5'd5; m.shift = 1; m.sdir = 1; end
            7: m.s = 5'd0;
            default: m.ill = 1;
        endcase
        if (m.ill)        m.w = 2;
        else if (m.shift) m.w = (sh == 0) ? 2 : sh + 2;
        else              m.w = 3;
        return m;
    endfunction

    task automatic drive(input bit st, input int op, input int sh);
        @(negedge Clock);
        Start  = st;
        Opcode = op[3:0];
        Shamt  = sh[3:0];
        if (st && (ecount + 1 >= next_free)) begin
            q.push_back(model(op, sh, ecount + 1));
            next_free = ecount + 1 + model(op, sh, 0).w + 1;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0);
    endtask

    task automatic do_reset();
        @(negedge Clock);
        Reset = 1'b1;
        Start = 1'b0;
        q.delete();
        next_free = 0;
        opcnt = 16'd0;
        @(posedge Clock);
        #1;
        chk("rst_busy", Busy, 0);
        chk("rst_done", Done, 0);
        chk("rst_we", WriteEn, 0);
        chk("rst_shen", ShiftEn, 0);
        chk("rst_s", S, 0);
        chk("rst_ctl", {Binvert, ShiftDir, Err}, 0);
`ifdef ALU_SEK_PERF_EN
        chk("rst_opcount", OpCount, 0);
`endif
        @(negedge Clock);
        Reset = 1'b0;
        started = 1'b1;
    endtask

    // Monitor: every cycle the DUT outputs must match the timeline of the active op (or idle).
    always @(negedge Clock) begin
        if (started && !Reset) begin
            op_t        f;
            int         rel;
            bit         act;
            logic [4:0] e_s;
            logic       e_b, e_d, e_busy, e_shen, e_done, e_we, e_err;
            act = (q.size() > 0) && (ecount >= q[0].acc);
            e_s = 0; e_b = 0; e_d = 0; e_busy = 0; e_shen = 0; e_done = 0; e_we = 0; e_err = 0;
            rel = 0;
            if (act) begin
                f      = q[0];
                rel    = ecount - f.acc;
                e_busy = 1;
                e_s    = f.s;
                e_b    = f.binv;
                e_d    = f.sdir;
                e_shen = f.shift && rel >= 1 && rel <= f.sh;
                e_done = (rel == f.w - 1);
                e_we   = e_done && !f.ill;
                e_err  = e_done && f.ill;
            end
            chk("busy", Busy, e_busy);
            chk("sel", S, e_s);
            chk("binvert", Binvert, e_b);
            chk("shiftdir", ShiftDir, e_d);
            chk("shiften", ShiftEn, e_shen);
            chk("done", Done, e_done);
            chk("writeen", WriteEn, e_we);
            chk("err", Err, e_err);
`ifdef ALU_SEK_PERF_EN
            chk("opcount", OpCount, opcnt);
`endif
            if (e_we) opcnt = opcnt + 16'd1;
            if (act && rel >= f.w - 1) void'(q.pop_front());
        end
    end

    initial begin
        do_reset();
        // directed: basic ops, shifts, illegal
        drive(1, 2, 0); idle(5);
        drive(1, 3, 0); idle(5);
        drive(1, 4, 0); idle(5);
        drive(1, 7, 0); idle(5);
        drive(1, 6, 5); idle(9);
        drive(1, 5, 0); idle(4);
        drive(1, 9, 0); idle(4);
        drive(1, 5, 1); idle(4);
        drive(1, 6, 15); idle(20);
        // Start held high across ops, opcode changing while busy
        for (int i = 0; i < 12; i++) drive(1, i % 8, 3);
        idle(10);
        // reset in cycle 4 of a Shamt=10 shift
        drive(1, 5, 10); idle(3);
        do_reset();
        idle(3);
        // randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) do_reset();
            else drive($urandom_range(0, 2) == 0, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
        end
        idle(30);
        chk("queue_drained", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
